// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC measurement pacer.
package tdc_pkg;

   localparam int COARSE_W_DEF = 16;
   localparam int FINE_W_DEF   = 8;
   localparam int DATA_W       = 24;

   localparam logic [DATA_W-1:0] TIMEOUT_WORD = 24'hFFFFFF;

   typedef enum logic {
      M_IDLE,
      M_RUN
   } meas_state_t;

   typedef enum logic [1:0] {
      O_IDLE,
      O_PULSE,
      O_GAP
   } out_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// Single-clock result buffer; head shows the oldest stored word.
// A push into a full FIFO lands only when a pop frees a slot on the same edge.
module tdc_sync_fifo
   import tdc_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] head,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tdc_meas_pacer.sv
// Start/stop interval measurement feeding a paced result stream to the UART framer.
// Optional: define TDC_TIMEOUT_EN to emit a timeout marker when the coarse count saturates.
module tdc_meas_pacer
   import tdc_pkg::*;
#(
   parameter  int COARSE_W   = COARSE_W_DEF,
   parameter  int FINE_W     = FINE_W_DEF,
   parameter  int FIFO_DEPTH = 8,
   parameter  int RDY_PULSE  = 4,
   parameter  int GAP_CYCLES = 2000,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk_20m,
   input  logic              rst,
   input  logic              start_in,
   input  logic              stop_in,
   input  logic [FINE_W-1:0] fine_code,
   output logic [DATA_W-1:0] data,
   output logic              data_rdy,
   output logic [CNT_W-1:0]  fifo_cnt,
   output logic [7:0]        drop_cnt
);

   localparam int OCNT_MAX = (GAP_CYCLES > RDY_PULSE) ? GAP_CYCLES : RDY_PULSE;
   localparam int OCNT_W   = $clog2(OCNT_MAX + 1);

   logic [2:0]          start_sh;
   logic [2:0]          stop_sh;
   logic                start_edge;
   logic                stop_edge;

   meas_state_t         meas_state, meas_next;
   logic [COARSE_W-1:0] coarse, coarse_next, coarse_inc;
   logic                push_req;
   logic [DATA_W-1:0]   push_word;

   out_state_t          out_state, out_next;
   logic [OCNT_W-1:0]   ocnt, ocnt_next;
   logic                rdy_next;
   logic                pop;

   logic [DATA_W-1:0]   fifo_head;
   logic                fifo_full;
   logic                fifo_empty;

   always_ff @(posedge clk_20m or posedge rst) begin
      if (rst) begin
         start_sh <= '0;
         stop_sh  <= '0;
      end else begin
         start_sh <= {start_sh[1:0], start_in};
         stop_sh  <= {stop_sh[1:0], stop_in};
      end
   end

   assign start_edge = start_sh[1] & ~start_sh[2];
   assign stop_edge  = stop_sh[1] & ~stop_sh[2];

   // The pushed count includes the stop cycle itself, so an N-cycle interval reads as N.
   always_comb begin
      meas_next   = meas_state;
      coarse_inc  = (coarse == '1) ? coarse : coarse + COARSE_W'(1);
      coarse_next = coarse;
      push_req    = 1'b0;
      push_word   = '0;
      case (meas_state)
         M_IDLE: begin
            if (start_edge) begin
               coarse_next = '0;
               meas_next   = M_RUN;
            end
         end
         M_RUN: begin
`ifdef TDC_TIMEOUT_EN
            if (coarse == '1) begin
               push_req  = 1'b1;
               push_word = TIMEOUT_WORD;
               meas_next = M_IDLE;
            end else if (stop_edge) begin
               push_req  = 1'b1;
               push_word = {coarse_inc, fine_code};
               meas_next = M_IDLE;
            end else begin
               coarse_next = coarse_inc;
            end
`else
            if (stop_edge) begin
               push_req  = 1'b1;
               push_word = {coarse_inc, fine_code};
               meas_next = M_IDLE;
            end else begin
               coarse_next = coarse_inc;
            end
`endif
         end
         default: meas_next = M_IDLE;
      endcase
   end

   always_ff @(posedge clk_20m or posedge rst) begin
      if (rst) begin
         meas_state <= M_IDLE;
         coarse     <= '0;
      end else begin
         meas_state <= meas_next;
         coarse     <= coarse_next;
      end
   end

   tdc_sync_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_20m),
      .rst   (rst),
      .push  (push_req),
      .pop   (pop),
      .wdata (push_word),
      .head  (fifo_head),
      .count (fifo_cnt),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk_20m or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (push_req && fifo_full && !pop) begin
         drop_cnt <= sat_inc8(drop_cnt);
      end
   end

   // One shared counter times both the valid pulse and the framer gap.
   always_comb begin
      out_next  = out_state;
      ocnt_next = ocnt;
      rdy_next  = data_rdy;
      pop       = 1'b0;
      case (out_state)
         O_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               rdy_next  = 1'b1;
               ocnt_next = '0;
               out_next  = O_PULSE;
            end
         end
         O_PULSE: begin
            if (ocnt == OCNT_W'(RDY_PULSE - 1)) begin
               rdy_next  = 1'b0;
               ocnt_next = '0;
               out_next  = O_GAP;
            end else begin
               ocnt_next = ocnt + OCNT_W'(1);
            end
         end
         O_GAP: begin
            if (ocnt == OCNT_W'(GAP_CYCLES - 1)) begin
               ocnt_next = '0;
               out_next  = O_IDLE;
            end else begin
               ocnt_next = ocnt + OCNT_W'(1);
            end
         end
         default: out_next = O_IDLE;
      endcase
   end

   always_ff @(posedge clk_20m or posedge rst) begin
      if (rst) begin
         out_state <= O_IDLE;
         ocnt      <= '0;
         data_rdy  <= 1'b0;
         data      <= '0;
      end else begin
         out_state <= out_next;
         ocnt      <= ocnt_next;
         data_rdy  <= rdy_next;
         if (pop) data <= fifo_head;
      end
   end

endmodule
